// File: rtl/sie_phase_sequencer.sv
// rtl/sie_phase_sequencer.sv - Schumann Ignition Event detector and phase sequencer
// Qualifies coherence, sequences ignition/plateau/propagation/decay/refractory, drives envelope and stats.
module sie_phase_sequencer #(
    parameter int WIDTH          = 18,
    parameter int FRAC           = 14,
    parameter int COH_HOLD       = 8,
    parameter int COH_TIMEOUT    = 1000,
    parameter int IGN_CYCLES     = 32,
    parameter int PLATEAU_CYCLES = 64,
    parameter int PROP_CYCLES    = 64,
    parameter int REFRACT_CYCLES = 200,
    parameter int ENV_STEP       = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] kuramoto_R,
    input  logic signed [WIDTH-1:0] boundary_power,
    input  logic signed [WIDTH-1:0] coh_thresh,
    input  logic signed [WIDTH-1:0] ign_thresh,
    output logic [2:0]              sie_phase,
    output logic                    sie_active,
    output logic signed [WIDTH-1:0] sie_envelope,
    output logic [15:0]             phase_timer,
    output logic [7:0]              ignition_count
);

    typedef enum logic [2:0] {
        PH_BASE  = 3'd0,
        PH_COH   = 3'd1,
        PH_IGN   = 3'd2,
        PH_PLAT  = 3'd3,
        PH_PROP  = 3'd4,
        PH_DECAY = 3'd5,
        PH_REFR  = 3'd6,
        PH_BAD   = 3'd7
    } phase_t;

    localparam int HW = (COH_HOLD > 1) ? $clog2(COH_HOLD) : 1;
    localparam logic [HW-1:0]           HOLD_LAST = HW'(COH_HOLD - 1);
    localparam logic signed [WIDTH:0]   ONE_X     = (WIDTH+1)'(1 << FRAC);
    localparam logic signed [WIDTH:0]   STEP_X    = (WIDTH+1)'(ENV_STEP);
    localparam logic signed [WIDTH-1:0] COH_DEF   = WIDTH'(11469);
    localparam logic signed [WIDTH-1:0] IGN_DEF   = WIDTH'(8192);
    localparam logic [15:0] T_COH  = 16'(COH_TIMEOUT - 1);
    localparam logic [15:0] T_IGN  = 16'(IGN_CYCLES - 1);
    localparam logic [15:0] T_PLAT = 16'(PLATEAU_CYCLES - 1);
    localparam logic [15:0] T_PROP = 16'(PROP_CYCLES - 1);
    localparam logic [15:0] T_REFR = 16'(REFRACT_CYCLES - 1);

    phase_t                  phase_q, phase_n;
    logic [15:0]             timer_q, timer_n;
    logic [HW-1:0]           hold_q, hold_n;
    logic signed [WIDTH-1:0] env_q, env_n;
    logic [7:0]              cnt_q, cnt_n;

    logic signed [WIDTH-1:0] coh_eff, ign_eff;
    logic signed [WIDTH:0]   env_x, env_up, env_dn;
    logic                    r_ge_coh, bp_ge_ign;

    // A zero threshold means "use the default"; anything else, negative included, is taken literally.
    assign coh_eff   = (coh_thresh == '0) ? COH_DEF : coh_thresh;
    assign ign_eff   = (ign_thresh == '0) ? IGN_DEF : ign_thresh;
    assign r_ge_coh  = kuramoto_R >= coh_eff;
    assign bp_ge_ign = boundary_power >= ign_eff;
    assign env_x     = env_q;
    assign env_up    = env_x + STEP_X;
    assign env_dn    = env_x - STEP_X;

    always_comb begin
        phase_n = phase_q;
        hold_n  = hold_q;
        env_n   = env_q;
        cnt_n   = cnt_q;
        timer_n = timer_q;
        case (phase_q)
            PH_BASE: begin
                env_n = '0;
                if (r_ge_coh) begin
                    if (hold_q == HOLD_LAST) begin
                        phase_n = PH_COH;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_q + HW'(1);
                    end
                end else begin
                    hold_n = '0;
                end
            end
            PH_COH: begin
                env_n = '0;
                if (bp_ge_ign) begin
                    phase_n = PH_IGN;
                    if (cnt_q != 8'hFF) cnt_n = cnt_q + 8'd1;
                end else if (!r_ge_coh || timer_q == T_COH) begin
                    phase_n = PH_BASE;
                end
            end
            PH_IGN: begin
                env_n = (env_up > ONE_X) ? ONE_X[WIDTH-1:0] : env_up[WIDTH-1:0];
                if (timer_q == T_IGN) begin
                    phase_n = PH_PLAT;
                    env_n   = ONE_X[WIDTH-1:0];
                end
            end
            PH_PLAT: begin
                env_n = ONE_X[WIDTH-1:0];
                if (timer_q == T_PLAT) phase_n = PH_PROP;
            end
            PH_PROP: begin
                env_n = ONE_X[WIDTH-1:0];
                if (timer_q == T_PROP) phase_n = PH_DECAY;
            end
            PH_DECAY: begin
                if (env_dn <= 0) begin
                    env_n   = '0;
                    phase_n = PH_REFR;
                end else begin
                    env_n = env_dn[WIDTH-1:0];
                end
            end
            PH_REFR: begin
                env_n = '0;
                if (timer_q == T_REFR) begin
                    phase_n = PH_BASE;
                    hold_n  = '0;
                end
            end
            default: begin
                phase_n = PH_BASE;
                env_n   = '0;
                hold_n  = '0;
            end
        endcase
        if (phase_n != phase_q) timer_n = '0;
        else if (timer_q != 16'hFFFF) timer_n = timer_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_BASE;
            timer_q <= '0;
            hold_q  <= '0;
            env_q   <= '0;
            cnt_q   <= '0;
        end else if (clk_en) begin
            phase_q <= phase_n;
            timer_q <= timer_n;
            hold_q  <= hold_n;
            env_q   <= env_n;
            cnt_q   <= cnt_n;
        end
    end

    assign sie_phase      = phase_q;
    assign sie_active     = (phase_q == PH_IGN) || (phase_q == PH_PLAT) || (phase_q == PH_PROP);
    assign sie_envelope   = env_q;
    assign phase_timer    = timer_q;
    assign ignition_count = cnt_q;

endmodule

// File: doc/sie_phase_sequencer.md
Name: sie_phase_sequencer

Overview:
Upstream stage of the coupling mode controller. It detects and sequences Schumann Ignition Events (SIE) from the Kuramoto order parameter and boundary power, and produces the 3-bit sie_phase code the controller consumes. It also provides an SIE envelope (Q14), an active flag and event statistics for downstream gain stages and debug.

Parameters:
WIDTH, 18, signed data width
FRAC, 14, fractional bits (ONE = 16384)
COH_HOLD, 8, consecutive enabled cycles with R >= coherence threshold needed to leave BASELINE
COH_TIMEOUT, 1000, max enabled cycles in COHERENCE without ignition
IGN_CYCLES, 32, IGNITION duration (enabled cycles)
PLATEAU_CYCLES, 64, PLATEAU duration
PROP_CYCLES, 64, PROPAGATION duration
REFRACT_CYCLES, 200, REFRACTORY duration
ENV_STEP, 512, envelope ramp step per enabled cycle (Q14)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
clk_en  in  1  update strobe; state advances only when high
kuramoto_R  in  WIDTH signed  order parameter, Q14
boundary_power  in  WIDTH signed  boundary band power, Q14
coh_thresh  in  WIDTH signed  coherence threshold; 0 selects default 11469 (0.7)
ign_thresh  in  WIDTH signed  ignition threshold; 0 selects default 8192 (0.5)
sie_phase  out  3  0 BASELINE, 1 COHERENCE, 2 IGNITION, 3 PLATEAU, 4 PROPAGATION, 5 DECAY, 6 REFRACTORY
sie_active  out  1  high in phases 2..4
sie_envelope  out  WIDTH signed  event envelope, Q14, range 0..16384
phase_timer  out  16  enabled cycles spent in current phase
ignition_count  out  8  number of ignitions, saturates at 255

Behaviour:
- Reset (async, immediate, independent of clk/clk_en): sie_phase=0, sie_active=0, sie_envelope=0, phase_timer=0, ignition_count=0, hold counter=0.
- All outputs are registered and change only on a rising clk edge with clk_en=1. clk_en=0 freezes everything.
- Threshold compares are signed, R >= thr. A threshold input of 0 selects its default. Any other value, including a negative one, is used as given.
- phase_timer clears to 0 on every phase change, otherwise increments and saturates at 65535.
- Fixed-duration phase lasting N cycles: transition on the enabled edge where phase_timer == N-1, so the phase lasts exactly N enabled cycles.
- BASELINE:
  - Hold counter increments when R >= coh; a single failing cycle clears it.
  - On the COH_HOLD-th consecutive qualifying edge -> COHERENCE, hold counter cleared.
- COHERENCE, priority order:
  1. boundary_power >= ign -> IGNITION; ignition_count++ (saturating).
  2. Else R < coh -> BASELINE.
  3. Else phase_timer == COH_TIMEOUT-1 -> BASELINE.
- IGNITION: envelope = min(env+ENV_STEP, 16384) each cycle. After IGN_CYCLES -> PLATEAU, envelope forced to 16384 on entry.
- PLATEAU: envelope held at 16384. After PLATEAU_CYCLES -> PROPAGATION.
- PROPAGATION: envelope held at 16384. After PROP_CYCLES -> DECAY.
- DECAY: envelope = max(env-ENV_STEP, 0). On the edge where the result is 0 -> REFRACTORY. Decay lasts ceil(16384/ENV_STEP) cycles (32 at default).
- REFRACTORY: all inputs ignored, envelope 0. After REFRACT_CYCLES -> BASELINE with hold counter 0, so a fresh COH_HOLD qualification is required.
- Illegal phase 7 -> BASELINE on the next enabled edge; envelope cleared.
- Inputs are sampled only on enabled edges. Input changes between enables have no effect.
- sie_active is decoded from the registered phase. It has the same timing as sie_phase and no extra latency.

Test Plan:
- Reset with inputs high -> phase=0, env=0, active=0, count=0. Reassert rst mid-PLATEAU between edges -> all outputs 0 immediately, before the next clk edge.
- R=13107, thresholds 0, boundary=0 -> phase 1 on the 8th enabled edge. Repeat with R=8192 on cycle 5 -> counter restarts, phase 1 on the 8th edge after R returns high.
- In COHERENCE, boundary=16384 -> phase 2 next enabled edge, ignition_count=1, active=1. Then +32 -> phase 3, env=16384; +64 -> phase 4; +64 -> phase 5, active=0.
- DECAY: env 16384 -> 15872 -> ... -> 0, phase 6 after 32 enabled edges. Hold R=13107, boundary=16384 -> still phase 6 for 200 edges, then phase 0, then phase 1 only after 8 more edges.
- R=13107, boundary=0 in COHERENCE -> phase 0 after 1000 enabled edges. Repeat with coh_thresh=14746 and R=13107 -> phase never leaves 0.
- clk_en toggling every other clock -> all durations counted in enabled edges only (IGNITION spans 64 clocks). Drive 256 ignitions -> ignition_count holds at 255.
